// File: rtl/quad_decoder_counter.sv
// x4 quadrature decoder: synchronize, glitch-filter, decode Gray steps into a wrapping up/down count.
// Latency SYNC_STAGES+FILTER_LEN edges from pin sample to count/pulse; no backpressure, pulses are unconditional.
module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_quad_a,
    input  logic             i_quad_b,
    output logic [WIDTH-1:0] o_count,
    output logic             o_dir,
    output logic             o_step_up,
    output logic             o_step_dn,
    output logic             o_err,
    output logic             o_err_sticky
);

    localparam int              RUN_W   = $clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic [1:0]             r_cand;
    logic [RUN_W-1:0]       r_run;
    logic [1:0]             r_f;
    logic [1:0]             r_f_d;
    logic                   r_primed;
    logic                   r_f_chg;
    logic [WIDTH-1:0]       r_count;
    logic                   r_dir;
    logic                   r_step_up;
    logic                   r_step_dn;
    logic                   r_err;
    logic                   r_err_sticky;

    logic [1:0]       w_sync;
    logic             w_sync_vld;
    logic             w_fresh;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_accept;
    logic [1:0]       w_delta;
    logic             w_up;
    logic             w_dn;
    logic             w_bad;

    // Position of a pin state along the up sequence 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        case (s)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    // Stale reset contents of the synchronizer must never count as a pin sample.
    assign w_sync     = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    assign w_sync_vld = r_sync_vld[SYNC_STAGES-1];
    assign w_fresh    = (w_sync != r_cand) || (r_run == '0);
    assign w_run_nxt  = w_fresh ? RUN_W'(1) : ((r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1);
    assign w_accept   = w_sync_vld && (w_run_nxt == RUN_MAX) && (!r_primed || (w_sync != r_f));

    assign w_delta = gray_pos(r_f) - gray_pos(r_f_d);
    assign w_up    = r_f_chg && (w_delta == 2'd1);
    assign w_dn    = r_f_chg && (w_delta == 2'd3);
    assign w_bad   = r_f_chg && (w_delta == 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_a     <= '0;
            r_sync_b     <= '0;
            r_sync_vld   <= '0;
            r_cand       <= 2'b00;
            r_run        <= '0;
            r_f          <= 2'b00;
            r_f_d        <= 2'b00;
            r_primed     <= 1'b0;
            r_f_chg      <= 1'b0;
            r_count      <= '0;
            r_dir        <= 1'b1;
            r_step_up    <= 1'b0;
            r_step_dn    <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_sync_a   <= {r_sync_a[SYNC_STAGES-2:0], i_quad_a};
            r_sync_b   <= {r_sync_b[SYNC_STAGES-2:0], i_quad_b};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};

            if (w_sync_vld) begin
                r_cand <= w_sync;
                r_run  <= w_run_nxt;
            end

            // The priming acceptance only seeds F; it never produces a decode.
            r_f_chg <= 1'b0;
            if (w_accept) begin
                r_f      <= w_sync;
                r_f_d    <= r_f;
                r_primed <= 1'b1;
                r_f_chg  <= r_primed;
            end

            r_step_up <= w_up;
            r_step_dn <= w_dn;
            r_err     <= w_bad;

            if (w_up) begin
                r_dir <= 1'b1;
            end else if (w_dn) begin
                r_dir <= 1'b0;
            end

            if (w_bad) begin
                r_err_sticky <= 1'b1;
            end else if (i_clear) begin
                r_err_sticky <= 1'b0;
            end

            if (i_clear) begin
                r_count <= '0;
            end else if (i_load) begin
                r_count <= i_load_value;
            end else if (i_enable && w_up) begin
                r_count <= r_count + 1'b1;
            end else if (i_enable && w_dn) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count      = r_count;
    assign o_dir        = r_dir;
    assign o_step_up    = r_step_up;
    assign o_step_dn    = r_step_dn;
    assign o_err        = r_err;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter: pin-walk table plus hand-written corner sequences.
module tb_quad_decoder_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic [1:0] pins;
    logic [7:0] o_count;
    logic       o_dir;
    logic       o_step_up;
    logic       o_step_dn;
    logic       o_err;
    logic       o_err_sticky;

    int n_assert;
    int n_fail;
    int n_up;
    int n_dn;
    int n_err;
    int n_multi;

    typedef struct {
        logic       clr;
        logic [1:0] pins;
        int         hold;
        logic [7:0] cnt;
        logic       dir;
        int         up;
        int         dn;
        int         er;
    } vec_t;

    vec_t tbl[6];

    quad_decoder_counter #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_clear      (clear),
        .i_load       (load),
        .i_load_value (load_value),
        .i_quad_a     (pins[1]),
        .i_quad_b     (pins[0]),
        .o_count      (o_count),
        .o_dir        (o_dir),
        .o_step_up    (o_step_up),
        .o_step_dn    (o_step_dn),
        .o_err        (o_err),
        .o_err_sticky (o_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance n edges; observe just after each edge and tally pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_up  += int'(o_step_up);
            n_dn  += int'(o_step_dn);
            n_err += int'(o_err);
            if ((int'(o_step_up) + int'(o_step_dn) + int'(o_err)) > 1) n_multi++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        tick(1);
        load       = 1'b0;
    endtask

    initial begin
        int b_up, b_dn, b_err;
        n_assert = 0; n_fail = 0; n_up = 0; n_dn = 0; n_err = 0; n_multi = 0;

        //           clr   pins   hold cnt    dir   up dn er
        tbl[0] = '{1'b0, 2'b10, 6, 8'd1,   1'b1, 1, 0, 0};
        tbl[1] = '{1'b0, 2'b11, 6, 8'd2,   1'b1, 1, 0, 0};
        tbl[2] = '{1'b0, 2'b01, 6, 8'd3,   1'b1, 1, 0, 0};
        tbl[3] = '{1'b0, 2'b00, 6, 8'd4,   1'b1, 1, 0, 0};
        tbl[4] = '{1'b1, 2'b01, 6, 8'd255, 1'b0, 0, 1, 0};
        tbl[5] = '{1'b0, 2'b00, 6, 8'd0,   1'b1, 1, 0, 0};

        reset = 1'b1; enable = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = 8'h00; pins = 2'b11;
        tick(3);
        reset = 1'b0;
        n_up = 0; n_dn = 0; n_err = 0;
        tick(10);
        chk("reset count", 32'(o_count), 32'd0);
        chk("reset dir", 32'(o_dir), 32'd1);
        chk("reset sticky", 32'(o_err_sticky), 32'd0);
        chk("reset pulses", 32'(n_up + n_dn + n_err), 32'd0);

        // Walk 11 -> 01 -> 00 (two up steps), then clear to start the table at 0.
        pins = 2'b01; tick(6);
        pins = 2'b00; tick(6);
        chk("prewalk count", 32'(o_count), 32'd2);
        pulse_clear();
        chk("clear count", 32'(o_count), 32'd0);

        for (int i = 0; i < 6; i++) begin
            b_up = n_up; b_dn = n_dn; b_err = n_err;
            if (tbl[i].clr) pulse_clear();
            pins = tbl[i].pins;
            tick(tbl[i].hold);
            chk($sformatf("row%0d count", i), 32'(o_count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d dir", i), 32'(o_dir), 32'(tbl[i].dir));
            chk($sformatf("row%0d up", i), 32'(n_up - b_up), 32'(tbl[i].up));
            chk($sformatf("row%0d dn", i), 32'(n_dn - b_dn), 32'(tbl[i].dn));
            chk($sformatf("row%0d err", i), 32'(n_err - b_err), 32'(tbl[i].er));
        end

        // Latency: pins change, first sampling edge k, count moves at k+5.
        pins = 2'b10;
        tick(5);
        chk("latency k+4 count", 32'(o_count), 32'd0);
        chk("latency k+4 step", 32'(o_step_up), 32'd0);
        tick(1);
        chk("latency k+5 count", 32'(o_count), 32'd1);
        chk("latency k+5 step", 32'(o_step_up), 32'd1);
        pins = 2'b00; tick(6);
        chk("back down count", 32'(o_count), 32'd0);

        // Glitch filter: 2-cycle pulse rejected, 3-cycle pulse accepted.
        b_up = n_up; b_dn = n_dn;
        pins = 2'b10; tick(2);
        pins = 2'b00; tick(10);
        chk("glitch2 up", 32'(n_up - b_up), 32'd0);
        chk("glitch2 dn", 32'(n_dn - b_dn), 32'd0);
        chk("glitch2 count", 32'(o_count), 32'd0);
        pins = 2'b10; tick(3);
        pins = 2'b00; tick(10);
        chk("glitch3 up", 32'(n_up - b_up), 32'd1);
        chk("glitch3 dn", 32'(n_dn - b_dn), 32'd1);
        chk("glitch3 count", 32'(o_count), 32'd0);

        // Illegal 00 -> 11 jump.
        do_load(8'h55);
        chk("load count", 32'(o_count), 32'h55);
        b_err = n_err;
        pins = 2'b11; tick(8);
        chk("err pulses", 32'(n_err - b_err), 32'd1);
        chk("err sticky", 32'(o_err_sticky), 32'd1);
        chk("err count", 32'(o_count), 32'h55);
        chk("err dir", 32'(o_dir), 32'd0);
        pulse_clear();
        chk("clr count", 32'(o_count), 32'd0);
        chk("clr sticky", 32'(o_err_sticky), 32'd0);

        // Load coinciding with an up step (11 -> 01): load wins, pulse still emitted.
        pins = 2'b01;
        tick(5);
        load = 1'b1; load_value = 8'h7F;
        tick(1);
        load = 1'b0;
        chk("load+step count", 32'(o_count), 32'h7F);
        chk("load+step pulse", 32'(o_step_up), 32'd1);
        chk("load+step dir", 32'(o_dir), 32'd1);
        tick(2);

        // enable=0: count frozen, pulses and dir still track.
        enable = 1'b0;
        b_up = n_up; b_dn = n_dn;
        pins = 2'b00; tick(6);
        chk("frozen up pulse", 32'(n_up - b_up), 32'd1);
        chk("frozen up count", 32'(o_count), 32'h7F);
        pins = 2'b01; tick(6);
        chk("frozen dn pulse", 32'(n_dn - b_dn), 32'd1);
        chk("frozen dn count", 32'(o_count), 32'h7F);
        chk("frozen dn dir", 32'(o_dir), 32'd0);
        enable = 1'b1;

        // err on the same edge as clear: sticky stays set.
        pins = 2'b10;
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("err+clr pulse", 32'(o_err), 32'd1);
        chk("err+clr sticky", 32'(o_err_sticky), 32'd1);
        chk("err+clr count", 32'(o_count), 32'd0);
        tick(1);
        pulse_clear();
        chk("late clr sticky", 32'(o_err_sticky), 32'd0);

        // Reset mid-operation with an illegal pin jump across it.
        do_load(8'h33);
        reset = 1'b1;
        pins  = 2'b01;
        tick(2);
        reset = 1'b0;
        b_up = n_up; b_dn = n_dn; b_err = n_err;
        tick(12);
        chk("rst2 pulses", 32'((n_up - b_up) + (n_dn - b_dn) + (n_err - b_err)), 32'd0);
        chk("rst2 count", 32'(o_count), 32'd0);
        chk("rst2 dir", 32'(o_dir), 32'd1);
        chk("rst2 sticky", 32'(o_err_sticky), 32'd0);

        chk("exclusive pulses", 32'(n_multi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Receive-side decoder for a two-phase quadrature position interface (phase A/B, x4 decoding).
- Synchronizes and glitch-filters the asynchronous pins, then decodes each legal Gray-code transition into one up or down step.
- Drives a wrapping up/down position counter and reports illegal transitions.
- Sits between external encoder pins and the control logic; direction and step outputs use the same up/down convention as the team's counters.

Parameters:
WIDTH, 8, position counter width in bits
SYNC_STAGES, 2, flops in each pin synchronizer (legal: ≥2)
FILTER_LEN, 3, consecutive identical synchronized samples required to accept a new pin state (legal: ≥1)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = count updates on decoded steps; 0 = count frozen
clear  input  1  synchronous: count←0, err_sticky←0
load  input  1  synchronous: count←load_value
load_value  input  WIDTH  value taken on load
quad_a  input  1  phase A pin, asynchronous
quad_b  input  1  phase B pin, asynchronous
count  output  WIDTH  position count
dir  output  1  last valid direction; 1 = up, 0 = down
step_up  output  1  one-cycle pulse per decoded up step
step_dn  output  1  one-cycle pulse per decoded down step
err  output  1  one-cycle pulse on illegal transition (both phases changed)
err_sticky  output  1  set by err; cleared by clear or reset

Behaviour:
- Reset, synchronous and active-high, while reset=1 at a clk edge:
  - count=0, dir=1, step_up=step_dn=err=err_sticky=0.
  - Synchronizer and filter registers = 0.
  - primed=0.
- Pin state S = {quad_a, quad_b}. Up sequence: 00→10→11→01→00 (A leads B). Down sequence is the reverse.
- Synchronizer: SYNC_STAGES flops per pin.
- Filter: filtered state F takes a new value only when the synchronized pair has held that same value for FILTER_LEN consecutive cycles. Shorter pulses are discarded.
- Priming: while primed=0, the first accepted filter value loads F and sets primed. No step, no err, and count is unchanged on that acceptance.
- Decode, one cycle after F changes while primed=1:
  - Legal up transition: step_up=1, dir=1, count+1 if enable.
  - Legal down transition: step_dn=1, dir=0, count−1 if enable.
  - Both bits changed: err=1, err_sticky=1, count and dir unchanged.
- Latency: let edge k be the first edge sampling a new pin level held stable. The count and pulse outputs change at edge k+SYNC_STAGES+FILTER_LEN (k+5 with defaults).
- Arithmetic: count wraps modulo 2^WIDTH in both directions.
- enable=0:
  - F keeps tracking the pins.
  - step_up, step_dn, dir and err still update.
  - count holds.
- Count priority per cycle: reset > clear > load > step.
  - Step pulses are still emitted when clear or load overrides the count.
  - An err event coinciding with clear leaves err_sticky=1 (the new event wins).
- Reset mid-operation: all state drops on that edge. Decoding restarts unprimed, so a pin state present at reset release never produces a spurious step or err.
- step_up, step_dn and err are mutually exclusive and at most one cycle wide per accepted transition.

Test Plan:
- Reset with pins held 11, release, wait 10 cycles -> count=0, dir=1, no step/err pulse.
- From count=0, drive pins 00→10→11→01→00, each held 6 cycles, enable=1 -> four step_up pulses; count=4; dir=1; first count change exactly 5 edges after the first pin edge is sampled.
- From count=0, drive one down step 00→01 -> step_dn pulse; count=255 (wrap); dir=0. Then drive 01→00 -> count=0.
- With pins at 00, pulse quad_a high for 2 cycles -> filter rejects it; no step; count unchanged. Pulse for 3 cycles -> one step_up and one step_dn; count returns to its original value.
- Jump pins 00→11 -> single err pulse; err_sticky=1; count and dir unchanged. Assert clear -> count=0, err_sticky=0.
- Assert load=1 (load_value=0x7F) in the same cycle as a decoded up step with clear=0 -> count=0x7F, step_up still pulses. Repeat with enable=0 -> count frozen while step pulses continue.
